// File: rtl/dsp_pkg.sv
// -----------------------------------------------------------------------------
// dsp_pkg
// Definitions shared by the DSP issue scheduler and its tag delay line.
//   - dsp_mode_t    : fracturable multiplier mode encodings
//   - sched_state_t : issue scheduler FSM states
//   - result widths and per-mode issue intervals
//   - helpers: effective_mode(), issue_interval(), res_width()
// -----------------------------------------------------------------------------
package dsp_pkg;

    typedef enum logic [1:0] {
        MODE_5X5 = 2'd0,
        MODE_5X9 = 2'd1,
        MODE_9X9 = 2'd2,
        MODE_ILL = 2'd3
    } dsp_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GAP   = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_t;

    // Width of the narrow operand lanes used by the 5-bit modes.
    localparam int NARROW_W = 5;

    // Valid product widths per mode; the 9x9 mode uses the full N+M bus.
    localparam int RES_W_5X5 = 10;
    localparam int RES_W_5X9 = 14;

    // Minimum cycles between consecutive issues in each mode.
    localparam int ISSUE_INTERVAL_5X5 = 1;
    localparam int ISSUE_INTERVAL_5X9 = 2;
    localparam int ISSUE_INTERVAL_9X9 = 1;

    // The illegal encoding is executed as a full-width multiply.
    function automatic logic [1:0] effective_mode(input logic [1:0] mode);
        return (mode == MODE_ILL) ? MODE_9X9 : mode;
    endfunction

    function automatic int issue_interval(input logic [1:0] mode);
        case (mode)
            MODE_5X5: return ISSUE_INTERVAL_5X5;
            MODE_5X9: return ISSUE_INTERVAL_5X9;
            default:  return ISSUE_INTERVAL_9X9;
        endcase
    endfunction

    function automatic int res_width(input logic [1:0] mode, input int full_w);
        case (mode)
            MODE_5X5: return RES_W_5X5;
            MODE_5X9: return RES_W_5X9;
            default:  return full_w;
        endcase
    endfunction

endpackage

// File: rtl/dsp_tag_delay.sv
// -----------------------------------------------------------------------------
// dsp_tag_delay
// DEPTH-stage shift register carrying {valid, tag, mode} alongside the DSP
// pipeline so each product can be matched with the request that produced it.
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   load_valid/load_tag/load_mode    : entry shifted in every cycle
//   tail_valid/tail_tag/tail_mode    : entry leaving the last stage
// -----------------------------------------------------------------------------
module dsp_tag_delay
    import dsp_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    input  logic [TAG_W-1:0] load_tag,
    input  logic [1:0]       load_mode,
    output logic             tail_valid,
    output logic [TAG_W-1:0] tail_tag,
    output logic [1:0]       tail_mode
);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic             valid_reg;
        logic [TAG_W-1:0] tag_reg;
        logic [1:0]       mode_reg;
        logic             valid_src;
        logic [TAG_W-1:0] tag_src;
        logic [1:0]       mode_src;

        if (gi == 0) begin : g_src
            assign valid_src = load_valid;
            assign tag_src   = load_tag;
            assign mode_src  = load_mode;
        end else begin : g_src
            assign valid_src = g_stage[gi-1].valid_reg;
            assign tag_src   = g_stage[gi-1].tag_reg;
            assign mode_src  = g_stage[gi-1].mode_reg;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_reg <= 1'b0;
                tag_reg   <= '0;
                mode_reg  <= '0;
            end else begin
                valid_reg <= valid_src;
                tag_reg   <= tag_src;
                mode_reg  <= mode_src;
            end
        end
    end

    assign tail_valid = g_stage[DEPTH-1].valid_reg;
    assign tail_tag   = g_stage[DEPTH-1].tag_reg;
    assign tail_mode  = g_stage[DEPTH-1].mode_reg;

endmodule

// File: rtl/dsp_issue_sched.sv
// -----------------------------------------------------------------------------
// dsp_issue_sched
// Issue scheduler in front of the fracturable DSP multiplier. Accepts tagged
// requests over valid/ready, enforces per-mode issue spacing, drains the DSP
// pipeline before a mode change, masks unused operand bits, and returns a
// tagged, width-masked result one cycle after the DSP output becomes valid.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   req_valid/req_ready        : request handshake
//   req_mode/req_a/req_b/req_tag : request payload
//   dsp_start/dsp_mode/dsp_aa/dsp_bb/dsp_cc : DSP inputs (registered)
//   dsp_out                    : DSP product
//   rsp_valid/rsp_tag/rsp_mode/rsp_data : registered result strobe
//   illegal_mode               : pulse when a mode-3 request is accepted
// -----------------------------------------------------------------------------
module dsp_issue_sched
    import dsp_pkg::*;
#(
    parameter int N       = 9,
    parameter int M       = 9,
    parameter int PIPES   = 0,
    parameter int DSP_LAT = PIPES + 1,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_mode,
    input  logic [N-1:0]     req_a,
    input  logic [M-1:0]     req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             dsp_start,
    output logic [1:0]       dsp_mode,
    output logic [N-1:0]     dsp_aa,
    output logic [M-1:0]     dsp_bb,
    output logic [N+M-1:0]   dsp_cc,
    input  logic [N+M-1:0]   dsp_out,
    output logic             rsp_valid,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [1:0]       rsp_mode,
    output logic [N+M-1:0]   rsp_data,
    output logic             illegal_mode
);

    localparam int W = N + M;

    // A request is outstanding from acceptance until its result is returned:
    // one cycle in the issue register, DSP_LAT cycles in the DSP, one cycle
    // waiting for the capture edge. Back-to-back issue can therefore have
    // DSP_LAT+2 requests outstanding.
    localparam int INF_W = $clog2(DSP_LAT + 3);

    // Delay line depth: one stage matching the DSP input sample, then
    // DSP_LAT stages matching the product latency.
    localparam int DELAY_DEPTH = DSP_LAT + 1;

    localparam logic [N-1:0] A_NARROW_MASK = N'((1 << NARROW_W) - 1);
    localparam logic [M-1:0] B_NARROW_MASK = M'((1 << NARROW_W) - 1);

    sched_state_t     state_reg, state_next;
    logic [INF_W-1:0] inflight_reg, inflight_next;
    logic [TAG_W-1:0] issue_tag_reg;

    logic [1:0]       eff_mode;
    logic             mode_change;
    logic             busy;
    logic             accept;
    logic [N-1:0]     aa_next;
    logic [M-1:0]     bb_next;

    logic             tail_valid;
    logic [TAG_W-1:0] tail_tag;
    logic [1:0]       tail_mode;

    function automatic logic [W-1:0] mask_result(input logic [W-1:0] data,
                                                 input logic [1:0]   mode);
        logic [W-1:0] msk;
        int           rw;
        msk = '0;
        rw  = res_width(mode, W);
        for (int i = 0; i < W; i++) begin
            msk[i] = (i < rw);
        end
        return data & msk;
    endfunction

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign eff_mode    = effective_mode(req_mode);
    assign mode_change = (eff_mode != dsp_mode);
    assign busy        = (inflight_reg != '0);
    assign req_ready   = (state_reg == ST_IDLE) && !(mode_change && busy);
    assign accept      = req_valid && req_ready;
    assign dsp_cc      = '0;

    // ------------------------------------------------------------------
    // Operand lane masking
    // ------------------------------------------------------------------
    always_comb begin
        aa_next = req_a;
        bb_next = req_b;
        case (eff_mode)
            MODE_5X5: begin
                aa_next = req_a & A_NARROW_MASK;
                bb_next = req_b & B_NARROW_MASK;
            end
            MODE_5X9: begin
                aa_next = req_a & A_NARROW_MASK;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (issue_interval(eff_mode) > 1) begin
                        state_next = ST_GAP;
                    end
                end else if (req_valid && mode_change && busy) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_GAP: begin
                state_next = ST_IDLE;
            end
            ST_DRAIN: begin
                if (!busy) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Issue register: operands and mode hold when nothing is accepted
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dsp_start     <= 1'b0;
            dsp_mode      <= '0;
            dsp_aa        <= '0;
            dsp_bb        <= '0;
            issue_tag_reg <= '0;
            illegal_mode  <= 1'b0;
        end else begin
            dsp_start    <= accept;
            illegal_mode <= accept && (req_mode == MODE_ILL);
            if (accept) begin
                dsp_mode      <= eff_mode;
                dsp_aa        <= aa_next;
                dsp_bb        <= bb_next;
                issue_tag_reg <= req_tag;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outstanding-request counter
    // ------------------------------------------------------------------
    always_comb begin
        inflight_next = inflight_reg;
        if (accept && !tail_valid) begin
            inflight_next = inflight_reg + INF_W'(1);
        end else if (!accept && tail_valid) begin
            inflight_next = inflight_reg - INF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_reg <= '0;
        end else begin
            inflight_reg <= inflight_next;
        end
    end

    // ------------------------------------------------------------------
    // Tag/mode delay line tracking the DSP pipeline
    // ------------------------------------------------------------------
    dsp_tag_delay #(
        .DEPTH (DELAY_DEPTH),
        .TAG_W (TAG_W)
    ) u_tag_delay (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (dsp_start),
        .load_tag   (issue_tag_reg),
        .load_mode  (dsp_mode),
        .tail_valid (tail_valid),
        .tail_tag   (tail_tag),
        .tail_mode  (tail_mode)
    );

    // ------------------------------------------------------------------
    // Retire: capture the DSP product when its tag reaches the tail
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_tag   <= '0;
            rsp_mode  <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= tail_valid;
            if (tail_valid) begin
                rsp_tag  <= tail_tag;
                rsp_mode <= tail_mode;
                rsp_data <= mask_result(dsp_out, tail_mode);
            end
        end
    end

endmodule

// File: tb/tb_dsp_issue_sched.sv
// -----------------------------------------------------------------------------
// tb_dsp_issue_sched
// Directed bench for dsp_issue_sched. A behavioural DSP model sets junk in
// the product bits above the active mode's result width so that result
// masking is observable. Three extra instances with PIPES=0..2 measure the
// acceptance-to-response latency.
// -----------------------------------------------------------------------------
module tb_dsp_issue_sched;

    localparam int N     = 9;
    localparam int M     = 9;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [1:0]       req_mode = '0;
    logic [N-1:0]     req_a = '0;
    logic [M-1:0]     req_b = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic             dsp_start;
    logic [1:0]       dsp_mode;
    logic [N-1:0]     dsp_aa;
    logic [M-1:0]     dsp_bb;
    logic [N+M-1:0]   dsp_cc;
    logic [N+M-1:0]   dsp_out;
    logic             rsp_valid;
    logic [TAG_W-1:0] rsp_tag;
    logic [1:0]       rsp_mode;
    logic [N+M-1:0]   rsp_data;
    logic             illegal_mode;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    // Product of the presented operands, with junk above the mode's width.
    function automatic logic [17:0] dsp_model(input logic [1:0] md,
                                              input logic [8:0] a,
                                              input logic [8:0] b);
        logic [17:0] p;
        p = {9'd0, a} * {9'd0, b};
        if (md == 2'd0) p = p | 18'h3FC00;
        else if (md == 2'd1) p = p | 18'h3C000;
        return p;
    endfunction

    // DSP model, PIPES=0: sample at start edge, output one edge later.
    logic [17:0] pipe0_s0, pipe0_s1;
    always @(posedge clk) begin
        pipe0_s0 <= dsp_model(dsp_mode, dsp_aa, dsp_bb);
        pipe0_s1 <= pipe0_s0;
    end
    assign dsp_out = pipe0_s1;

    dsp_issue_sched #(.N(N), .M(M), .PIPES(0), .TAG_W(TAG_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_mode     (req_mode),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_tag      (req_tag),
        .dsp_start    (dsp_start),
        .dsp_mode     (dsp_mode),
        .dsp_aa       (dsp_aa),
        .dsp_bb       (dsp_bb),
        .dsp_cc       (dsp_cc),
        .dsp_out      (dsp_out),
        .rsp_valid    (rsp_valid),
        .rsp_tag      (rsp_tag),
        .rsp_mode     (rsp_mode),
        .rsp_data     (rsp_data),
        .illegal_mode (illegal_mode)
    );

    // Latency probes for PIPES = 0, 1, 2.
    logic       probe_valid = 1'b0;
    logic [2:0] probe_rsp;
    logic [2:0] probe_rdy;

    for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
        localparam int LAT = gi + 1;
        logic             p_start, p_ill, p_rv;
        logic [1:0]       p_dm, p_rm;
        logic [N-1:0]     p_aa;
        logic [M-1:0]     p_bb;
        logic [N+M-1:0]   p_cc, p_out, p_rd;
        logic [TAG_W-1:0] p_rt;
        logic [17:0]      pipe [0:LAT];

        always @(posedge clk) begin
            pipe[0] <= dsp_model(p_dm, p_aa, p_bb);
            for (int k = 1; k <= LAT; k++) pipe[k] <= pipe[k-1];
        end
        assign p_out = pipe[LAT];

        dsp_issue_sched #(.N(N), .M(M), .PIPES(gi), .TAG_W(TAG_W)) u_probe (
            .clk          (clk),
            .rst_n        (rst_n),
            .req_valid    (probe_valid),
            .req_ready    (probe_rdy[gi]),
            .req_mode     (2'd2),
            .req_a        (9'h003),
            .req_b        (9'h004),
            .req_tag      (4'h1),
            .dsp_start    (p_start),
            .dsp_mode     (p_dm),
            .dsp_aa       (p_aa),
            .dsp_bb       (p_bb),
            .dsp_cc       (p_cc),
            .dsp_out      (p_out),
            .rsp_valid    (p_rv),
            .rsp_tag      (p_rt),
            .rsp_mode     (p_rm),
            .rsp_data     (p_rd),
            .illegal_mode (p_ill)
        );
        assign probe_rsp[gi] = p_rv;
    end

    // Response monitor.
    logic [TAG_W-1:0] rq_tag [$];
    logic [1:0]       rq_mode [$];
    logic [17:0]      rq_data [$];

    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            rq_tag.push_back(rsp_tag);
            rq_mode.push_back(rsp_mode);
            rq_data.push_back(rsp_data);
        end
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic [1:0] md, input logic [8:0] a,
                           input logic [8:0] b, input logic [3:0] t);
        req_valid = v;
        req_mode  = md;
        req_a     = a;
        req_b     = b;
        req_tag   = t;
    endtask

    task automatic wait_rsp(input string name, input int n);
        for (int k = 0; k < 40 && rq_data.size() < n; k++) tick();
        check(name, rq_data.size(), n);
    endtask

    task automatic pop_rsp(output logic [3:0] t, output logic [1:0] m, output logic [17:0] d);
        if (rq_data.size() > 0) begin
            t = rq_tag.pop_front();
            m = rq_mode.pop_front();
            d = rq_data.pop_front();
        end else begin
            t = 'x;
            m = 'x;
            d = 'x;
        end
    endtask

    function automatic void flush_rsp();
        rq_tag.delete();
        rq_mode.delete();
        rq_data.delete();
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0]  t;
        logic [1:0]  m;
        logic [17:0] d;
        logic [8:0]  ba [0:19];
        logic [8:0]  bb [0:19];
        int          acc;
        int          seen;
        int          lat [0:2];

        // ---------------- reset ----------------
        tick();
        tick();
        check("rst_dsp_start", dsp_start, 0);
        check("rst_dsp_mode", dsp_mode, 0);
        check("rst_dsp_aa", dsp_aa, 0);
        check("rst_dsp_bb", dsp_bb, 0);
        check("rst_dsp_cc", dsp_cc, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_tag", rsp_tag, 0);
        check("rst_illegal", illegal_mode, 0);
        rst_n = 1'b1;
        #1;
        check("rst_ready", req_ready, 1);
        tick();

        // ---------------- mode 0 directed + latency ----------------
        set_req(1, 2'd0, 9'h1F3, 9'h015, 4'd5);
        #1;
        check("m0_ready", req_ready, 1);
        tick();
        set_req(0, 2'd0, 9'h000, 9'h000, 4'd0);
        check("m0_start", dsp_start, 1);
        check("m0_aa", dsp_aa, 32'h013);
        check("m0_bb", dsp_bb, 32'h015);
        check("m0_mode", dsp_mode, 0);
        tick();
        check("m0_start_drop", dsp_start, 0);
        tick();
        check("m0_rsp_early", rsp_valid, 0);
        tick();
        check("m0_rsp_valid", rsp_valid, 1);
        check("m0_rsp_data", rsp_data, 32'h18F);
        check("m0_rsp_tag", rsp_tag, 5);
        check("m0_rsp_mode", rsp_mode, 0);
        tick();
        check("m0_rsp_pulse", rsp_valid, 0);
        flush_rsp();

        // ---------------- mode 0 back-to-back ----------------
        for (int i = 0; i < 20; i++) begin
            ba[i] = 9'(i * 37 + 11);
            bb[i] = 9'(i * 53 + 7);
            set_req(1, 2'd0, ba[i], bb[i], 4'(i % 16));
            #1;
            check("b2b_ready", req_ready, 1);
            tick();
        end
        set_req(0, 2'd0, 9'h000, 9'h000, 4'd0);
        wait_rsp("b2b_count", 20);
        for (int i = 0; i < 20; i++) begin
            pop_rsp(t, m, d);
            check("b2b_tag", t, i % 16);
            check("b2b_data", d, (ba[i] & 9'h1F) * (bb[i] & 9'h1F));
        end
        tick();

        // ---------------- mode 1 spacing ----------------
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            set_req(1, 2'd1, 9'h1FF, 9'h1FF, 4'(8 + acc));
            #1;
            check("m1_ready_alt", req_ready, (c % 2 == 0) ? 1 : 0);
            if (req_ready) acc++;
            tick();
            if (c == 0) begin
                check("m1_aa", dsp_aa, 32'h01F);
                check("m1_bb", dsp_bb, 32'h1FF);
                check("m1_mode", dsp_mode, 1);
            end
        end
        set_req(0, 2'd0, 9'h000, 9'h000, 4'd0);
        wait_rsp("m1_count", 3);
        for (int i = 0; i < 3; i++) begin
            pop_rsp(t, m, d);
            check("m1_tag", t, 8 + i);
            check("m1_rsp_mode", m, 1);
            check("m1_data", d, 32'h3DE1);
        end
        tick();

        // ---------------- mode change drain ----------------
        for (int i = 0; i < 3; i++) begin
            set_req(1, 2'd0, 9'h003, 9'(i + 1), 4'(i + 1));
            #1;
            check("drain_burst_ready", req_ready, 1);
            tick();
        end
        set_req(1, 2'd2, 9'h005, 9'h006, 4'd4);
        seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            #1;
            check("drain_ready", req_ready, (rq_data.size() == 3) ? 1 : 0);
            if (req_ready) seen = 1;
            tick();
        end
        check("drain_ready_seen", seen, 1);
        set_req(0, 2'd0, 9'h000, 9'h000, 4'd0);
        check("drain_issue_start", dsp_start, 1);
        check("drain_issue_mode", dsp_mode, 2);
        check("drain_issue_aa", dsp_aa, 32'h005);
        wait_rsp("drain_count", 4);
        for (int i = 0; i < 3; i++) begin
            pop_rsp(t, m, d);
            check("drain_old_tag", t, i + 1);
            check("drain_old_data", d, 3 * (i + 1));
        end
        pop_rsp(t, m, d);
        check("drain_new_mode", m, 2);
        check("drain_new_data", d, 30);
        tick();

        // ---------------- illegal mode ----------------
        set_req(1, 2'd3, 9'h100, 9'h100, 4'd9);
        #1;
        check("ill_ready", req_ready, 1);
        tick();
        set_req(0, 2'd0, 9'h000, 9'h000, 4'd0);
        check("ill_pulse", illegal_mode, 1);
        check("ill_dsp_mode", dsp_mode, 2);
        tick();
        check("ill_pulse_end", illegal_mode, 0);
        wait_rsp("ill_count", 1);
        pop_rsp(t, m, d);
        check("ill_rsp_mode", m, 2);
        check("ill_rsp_data", d, 32'h10000);
        check("ill_rsp_tag", t, 9);
        tick();

        // ---------------- reset mid-operation ----------------
        flush_rsp();
        set_req(1, 2'd2, 9'h001, 9'h001, 4'd10);
        tick();
        set_req(1, 2'd2, 9'h001, 9'h001, 4'd11);
        tick();
        set_req(0, 2'd0, 9'h000, 9'h000, 4'd0);
        rst_n = 1'b0;
        #1;
        check("arst_dsp_start", dsp_start, 0);
        check("arst_dsp_mode", dsp_mode, 0);
        check("arst_dsp_aa", dsp_aa, 0);
        check("arst_rsp_valid", rsp_valid, 0);
        check("arst_rsp_tag", rsp_tag, 0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) tick();
        check("arst_no_rsp", rq_data.size(), 0);
        set_req(1, 2'd0, 9'h007, 9'h009, 4'd12);
        #1;
        check("arst_ready", req_ready, 1);
        tick();
        set_req(0, 2'd0, 9'h000, 9'h000, 4'd0);
        wait_rsp("arst_count", 1);
        pop_rsp(t, m, d);
        check("arst_tag", t, 12);
        check("arst_data", d, 63);

        // ---------------- latency sweep ----------------
        probe_valid = 1'b1;
        #1;
        check("sweep_ready", probe_rdy, 3'b111);
        tick();
        probe_valid = 1'b0;
        for (int i = 0; i < 3; i++) lat[i] = 0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                if (probe_rsp[i] === 1'b1 && lat[i] == 0) lat[i] = e;
            end
        end
        check("sweep_lat_p0", lat[0], 3);
        check("sweep_lat_p1", lat[1], 4);
        check("sweep_lat_p2", lat[2], 5);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
